// File: rtl/data_sram_resp_pkg.sv
// Shared constants for the data-SRAM responder.
// MMIO window base and register offsets, plus a lane-merge helper.
package data_sram_resp_pkg;

  localparam logic [15:0] MMIO_BASE     = 16'hbfaf;

  localparam logic [15:0] LED_OFS       = 16'hf020;
  localparam logic [15:0] NUM_OFS       = 16'hf050;
  localparam logic [15:0] SWITCH_OFS    = 16'hf060;
  localparam logic [15:0] TIMER_OFS     = 16'he000;
  localparam logic [15:0] SIMU_FLAG_OFS = 16'hff04;
  localparam logic [15:0] IO_SIMU_OFS   = 16'hffec;

  function automatic logic [31:0] lane_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  we
  );
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_sram_resp_bytewe_ram.sv
// Single-port read-first RAM, 4 byte lanes, registered read.
// Read data holds while en is low.
module bytewe_ram #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: byte-lane RAM plus confreg-style MMIO window.
// One-cycle read-first response for both RAM and MMIO targets.
module data_sram_resp #(
  parameter int          RAM_AW        = 16,
  parameter logic [15:0] MMIO_BASE     = data_sram_resp_pkg::MMIO_BASE,
  parameter logic [31:0] SIMU_FLAG_VAL = 32'hffff_ffff,
  parameter logic [31:0] TIMER_RST     = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out
);

  import data_sram_resp_pkg::*;

  logic [15:0] ofs;
  logic        is_mmio;
  logic        req;
  logic        mmio_wr;

  assign ofs     = data_sram_addr[15:0];
  assign is_mmio = data_sram_addr[31:16] == MMIO_BASE;
  assign req     = data_sram_en & ~reset;
  assign mmio_wr = req & is_mmio & (|data_sram_we);

  logic hit_led, hit_num, hit_sw;
  logic hit_tmr, hit_flag, hit_io;

  assign hit_led  = ofs == LED_OFS;
  assign hit_num  = ofs == NUM_OFS;
  assign hit_sw   = ofs == SWITCH_OFS;
  assign hit_tmr  = ofs == TIMER_OFS;
  assign hit_flag = ofs == SIMU_FLAG_OFS;
  assign hit_io   = ofs == IO_SIMU_OFS;

  logic [15:0] led_q;
  logic [31:0] num_q;
  logic [31:0] io_q;
  logic [31:0] timer_q;
  logic [7:0]  sw_s1;
  logic [7:0]  sw_s2;
  logic [31:0] mmio_q;
  logic        is_mmio_q;

  logic [31:0] led_wr;
  logic [31:0] num_wr;
  logic [31:0] io_wr;
  logic [31:0] tmr_wr;
  logic [31:0] io_swap;

  assign io_swap = {data_sram_wdata[15:0], data_sram_wdata[31:16]};

  // LED is only 16 bits wide, so the upper lanes are dropped
  assign led_wr = lane_merge({16'h0, led_q}, data_sram_wdata,
                             {2'b00, data_sram_we[1:0]});
  assign num_wr = lane_merge(num_q, data_sram_wdata, data_sram_we);
  assign io_wr  = lane_merge(io_q, io_swap, data_sram_we);
  assign tmr_wr = lane_merge(timer_q, data_sram_wdata, data_sram_we);

  logic [31:0] mmio_rd;

  always_comb begin
    mmio_rd = '0;
    unique case (1'b1)
      hit_led:  mmio_rd = {16'h0, led_q};
      hit_num:  mmio_rd = num_q;
      hit_sw:   mmio_rd = {24'h0, sw_s2};
      hit_tmr:  mmio_rd = timer_q;
      hit_flag: mmio_rd = SIMU_FLAG_VAL;
      hit_io:   mmio_rd = io_q;
      default:  mmio_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      num_q     <= '0;
      io_q      <= '0;
      timer_q   <= TIMER_RST;
      sw_s1     <= '0;
      sw_s2     <= '0;
      mmio_q    <= '0;
      is_mmio_q <= 1'b1;
    end else begin
      if (mmio_wr && hit_led) led_q <= led_wr[15:0];
      if (mmio_wr && hit_num) num_q <= num_wr;
      if (mmio_wr && hit_io)  io_q  <= io_wr;
      timer_q <= (mmio_wr && hit_tmr) ? tmr_wr : timer_q + 32'd1;
      sw_s1   <= switch_in;
      sw_s2   <= sw_s1;
      if (req) begin
        is_mmio_q <= is_mmio;
        if (is_mmio) mmio_q <= mmio_rd;
      end
    end
  end

  logic [31:0] ram_rdata;

  bytewe_ram #(
    .AW(RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (req & ~is_mmio),
    .we    (data_sram_we),
    .addr  (data_sram_addr[RAM_AW+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_rdata)
  );

  // Reset parks the select on the cleared MMIO register so rdata reads 0
  assign data_sram_rdata = is_mmio_q ? mmio_q : ram_rdata;
  assign led_out         = led_q;
  assign num_out         = num_q;

  logic unused_addr;
  assign unused_addr = ^data_sram_addr[1:0];

endmodule
